// File: rtl/dkong_uart_pkg.sv
// Shared definitions for the dkong UART transmitter and its matching receiver.
// Macro DKONG_UART_PARITY_EN adds the PARITY state to the frame encoding.
package dkong_uart_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef DKONG_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dkong_uart_fifo.sv
// Synchronous FIFO with full/empty/count. Pointers carry one extra wrap bit
// so full and empty are distinguishable when the index bits match.
module dkong_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; both may move on the same edge, leaving count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    // NOTE: the array has no reset; empty slots are never read, and leaving it
    // out lets the storage map onto plain RAM/flops without a reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dkong_uart_tx.sv
// UART transmitter: FIFO-buffered, 8N1 frames (8E1 with DKONG_UART_PARITY_EN).
// ser_out and busy are registered from the current state, so both trail the
// FSM by one cycle and stay aligned with each other.
module dkong_uart_tx
    import dkong_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          masterclk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          ser_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          next_state;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic [7:0]           fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 line_bit;
`ifdef DKONG_UART_PARITY_EN
    logic                 parity_bit;
`endif

    assign tx_ready = !fifo_full && !rst;
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (clk_cnt == LAST_CLK);

    dkong_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (masterclk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge masterclk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state and pop decision; pops happen only at frame boundaries.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    next_state = ST_START;
                    pop        = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) next_state = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_idx == LAST_BIT) begin
`ifdef DKONG_UART_PARITY_EN
                    next_state = ST_PARITY;
`else
                    next_state = ST_STOP;
`endif
                end
            end
`ifdef DKONG_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end) next_state = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        next_state = ST_START;
                        pop        = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Line level for the bit the FSM is currently in.
    always_comb begin
        line_bit = STOP_BIT;
        case (state)
            ST_START:  line_bit = START_BIT;
            ST_DATA:   line_bit = shreg[0];
`ifdef DKONG_UART_PARITY_EN
            ST_PARITY: line_bit = parity_bit;
`endif
            default:   line_bit = STOP_BIT;
        endcase
    end

    // Bit timing, shift register and registered line/busy outputs.
    always_ff @(posedge masterclk) begin
        if (rst) begin
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            ser_out    <= STOP_BIT;
            busy       <= 1'b0;
`ifdef DKONG_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            ser_out <= line_bit;
            busy    <= (state != ST_IDLE) || !fifo_empty;

            if (state == ST_IDLE || bit_end) clk_cnt <= '0;
            else                             clk_cnt <= clk_cnt + 1'b1;

            if (pop) begin
                shreg      <= fifo_head;
                bit_idx    <= '0;
`ifdef DKONG_UART_PARITY_EN
                parity_bit <= even_parity(fifo_head);
`endif
            end else if (state == ST_DATA && bit_end) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dkong_uart_tx.sv
// Directed bench for dkong_uart_tx: instance A (CLKS_PER_BIT=4) and
// instance B (CLKS_PER_BIT=1). ser_out/busy are logged every cycle and
// frames are checked against expected bit sequences afterwards.
module tb_dkong_uart_tx;

    localparam int CPB_A = 4;
    localparam int CPB_B = 1;
    localparam int DEPTH = 4;
`ifdef DKONG_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int LOG_N = 4096;

    logic       masterclk;
    logic       rst;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       tx_ready_a, tx_ready_b;
    logic       ser_a, ser_b;
    logic       busy_a, busy_b;
    logic [2:0] count_a, count_b;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic log_a      [LOG_N];
    logic busy_log_a [LOG_N];
    logic log_b      [LOG_N];

    dkong_uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .masterclk  (masterclk),
        .rst        (rst),
        .tx_data    (tx_data_a),
        .tx_valid   (tx_valid_a),
        .tx_ready   (tx_ready_a),
        .ser_out    (ser_a),
        .busy       (busy_a),
        .fifo_count (count_a)
    );

    dkong_uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .masterclk  (masterclk),
        .rst        (rst),
        .tx_data    (tx_data_b),
        .tx_valid   (tx_valid_b),
        .tx_ready   (tx_ready_b),
        .ser_out    (ser_b),
        .busy       (busy_b),
        .fifo_count (count_b)
    );

    initial masterclk = 1'b0;
    always #5 masterclk = ~masterclk;

    // Cycle index: value after the n-th rising edge.
    always @(posedge masterclk) cyc <= cyc + 1;

    // Log outputs mid-cycle, indexed by the edge that produced them.
    always @(negedge masterclk) begin
        if (cyc < LOG_N) begin
            log_a[cyc]      <= ser_a;
            busy_log_a[cyc] <= busy_a;
            log_b[cyc]      <= ser_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge masterclk);
    endtask

    // Expected line level for frame bit j of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef DKONG_UART_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic sample(input bit use_b, input int idx);
        if (idx < 0 || idx >= LOG_N) return 1'bx;
        return use_b ? log_b[idx] : log_a[idx];
    endfunction

    // Every cycle of every bit of one frame starting at log index s.
    task automatic verify_frame(input bit use_b, input int s, input int cpb,
                                input logic [7:0] b, input string tag);
        for (int j = 0; j < FB; j++)
            for (int c = 0; c < cpb; c++)
                check($sformatf("%s bit%0d cyc%0d", tag, j, c),
                      sample(use_b, s + j*cpb + c), exp_bit(b, j));
    endtask

    // Offer one byte at a negedge; returns the log index of the accept edge.
    task automatic push_a(input logic [7:0] d, output int k);
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        @(negedge masterclk);
        k          = cyc;
        tx_valid_a = 1'b0;
        tx_data_a  = 8'hEE;
    endtask

    task automatic push_b(input logic [7:0] d, output int k);
        tx_data_b  = d;
        tx_valid_b = 1'b1;
        @(negedge masterclk);
        k          = cyc;
        tx_valid_b = 1'b0;
        tx_data_b  = 8'hEE;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, k2, s;
        int exp_cnt [8] = '{1, 1, 2, 3, 4, 4, 4, 4};
        logic [7:0] full_bytes [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

        rst        = 1'b1;
        tx_data_a  = 8'h00;
        tx_data_b  = 8'h00;
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;

        // Reset state
        tick(3);
        check("rst ser_a",    ser_a,      1);
        check("rst busy_a",   busy_a,     0);
        check("rst count_a",  count_a,    0);
        check("rst ready_a",  tx_ready_a, 0);
        check("rst ser_b",    ser_b,      1);
        check("rst ready_b",  tx_ready_b, 0);
        rst = 1'b0;
        #1;
        check("ready after rst", tx_ready_a, 1);
        tick(2);

        // Basic frame 0xA5: start bit two edges after acceptance
        push_a(8'hA5, k);
        tick(FB*CPB_A + 6);
        check("a5 lead idle", sample(0, k + 1), 1);
        verify_frame(0, k + 2, CPB_A, 8'hA5, "a5");
        check("a5 tail idle", sample(0, k + 2 + FB*CPB_A), 1);

        // Back-to-back 0x00 then 0xFF on consecutive edges
        tx_data_a  = 8'h00;
        tx_valid_a = 1'b1;
        @(negedge masterclk);
        k          = cyc;
        tx_data_a  = 8'hFF;
        @(negedge masterclk);
        tx_valid_a = 1'b0;
        tx_data_a  = 8'hEE;
        tick(2*FB*CPB_A + 6);
        verify_frame(0, k + 2, CPB_A, 8'h00, "b2b0");
        verify_frame(0, k + 2 + FB*CPB_A, CPB_A, 8'hFF, "b2b1");
        s = k + 2 + 2*FB*CPB_A - 1;
        check("b2b busy mid",      busy_log_a[k + 2 + FB*CPB_A], 1);
        check("b2b busy last stop", busy_log_a[s], 1);
        check("b2b busy drop",     busy_log_a[s + 1], 0);

        // FIFO full with tx_valid held; data changes every cycle
        tx_valid_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_data_a = 8'h10 + 8'(i);
            check($sformatf("full ready%0d", i), tx_ready_a, (i < 5) ? 1 : 0);
            @(negedge masterclk);
            if (i == 0) k = cyc;
            check($sformatf("full count%0d", i), count_a, exp_cnt[i]);
        end
        tx_valid_a = 1'b0;
        tx_data_a  = 8'hEE;
        tick(5*FB*CPB_A + 10);
        for (int f = 0; f < 5; f++)
            verify_frame(0, k + 2 + f*FB*CPB_A, CPB_A, full_bytes[f], $sformatf("full%0d", f));
        check("full no extra frame", sample(0, k + 2 + 5*FB*CPB_A), 1);
        check("full drained", count_a, 0);

        // Parity-sensitive bytes; frame length checked by the tail idle
        push_a(8'h07, k);
        tick(FB*CPB_A + 6);
        verify_frame(0, k + 2, CPB_A, 8'h07, "p07");
        check("p07 tail idle", sample(0, k + 2 + FB*CPB_A), 1);
`ifdef DKONG_UART_PARITY_EN
        check("p07 parity", sample(0, k + 2 + 9*CPB_A), 1);
`endif
        push_a(8'h03, k);
        tick(FB*CPB_A + 6);
        verify_frame(0, k + 2, CPB_A, 8'h03, "p03");
        check("p03 tail idle", sample(0, k + 2 + FB*CPB_A), 1);
`ifdef DKONG_UART_PARITY_EN
        check("p03 parity", sample(0, k + 2 + 9*CPB_A), 0);
`endif

        // Mid-frame reset during data bit 3 of 0x52 (bit3 = 0), one byte queued
        push_a(8'h52, k);
        push_a(8'h66, k2);
        tick(k + 2 + 4*CPB_A + 1 - cyc);
        check("mid pre-rst bit3", ser_a, 0);
        check("mid pre-rst count", count_a, 1);
        rst = 1'b1;
        @(negedge masterclk);
        check("mid rst ser",   ser_a,   1);
        check("mid rst count", count_a, 0);
        check("mid rst busy",  busy_a,  0);
        rst = 1'b0;
        #1;
        check("mid ready after rst", tx_ready_a, 1);
        push_a(8'h3C, k);
        tick(FB*CPB_A + 6);
        check("3c lead idle", sample(0, k + 1), 1);
        verify_frame(0, k + 2, CPB_A, 8'h3C, "3c");
        check("3c tail idle", sample(0, k + 2 + FB*CPB_A), 1);

        // One cycle per bit on instance B
        push_b(8'h81, k);
        tick(FB*CPB_B + 6);
        check("81 lead idle", sample(1, k + 1), 1);
        verify_frame(1, k + 2, CPB_B, 8'h81, "81");
        check("81 tail idle", sample(1, k + 2 + FB*CPB_B), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dkong_uart_tx.md
DKONG_UART_TX -- requirements
Module: dkong_uart_tx

Interface
- REQ-001 The block SHALL expose parameter CLKS_PER_BIT, default 1, meaning masterclk cycles per serial bit period; legal values are 1 and above.
- REQ-002 The block SHALL expose parameter FIFO_DEPTH, default 4, meaning the number of bytes buffered ahead of the shifter; legal values are powers of two, 2 and above.
- REQ-003 masterclk  in  1  sole clock; all state SHALL update on its rising edge.
- REQ-004 rst  in  1  synchronous active-high reset, sampled on the masterclk rising edge.
- REQ-005 tx_data  in  8  byte to transmit, qualified by tx_valid.
- REQ-006 tx_valid  in  1  producer offers tx_data this cycle.
- REQ-007 tx_ready  out  1  FIFO not full; a byte is accepted on each edge where tx_valid and tx_ready are both high.
- REQ-008 ser_out  out  1  registered serial line; idle level is 1.
- REQ-009 busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- REQ-010 fifo_count  out  clog2(FIFO_DEPTH)+1  number of bytes currently held in the FIFO.

Function
- REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, an optional parity bit (REQ-024), then 1 stop bit (1).
- REQ-012 Each bit SHALL drive ser_out for exactly CLKS_PER_BIT consecutive cycles, timed by a bit-period counter that restarts at 0 at every bit boundary.
- REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
- REQ-014 IDLE -> START SHALL occur on an edge where the FIFO is non-empty; the FIFO head is popped into the shift register on that same edge.
- REQ-015 START -> DATA, DATA -> DATA (8 bits), DATA -> PARITY or STOP, and PARITY -> STOP SHALL each occur when the bit counter reaches CLKS_PER_BIT-1.
- REQ-016 STOP SHALL end after its full period; at that point the FSM goes to START with the next pop if the FIFO is non-empty, otherwise to IDLE, so back-to-back frames have no idle gap.
- REQ-017 Latency: when the FIFO is empty and the FSM is IDLE, a byte accepted on edge k SHALL drive ser_out to 0 from edge k+2.
- REQ-018 On a simultaneous push and pop, fifo_count SHALL be unchanged and both operations SHALL take effect.
- REQ-019 When the FIFO is full, tx_ready SHALL be 0, tx_valid SHALL be ignored, and no byte is overwritten. When full and a pop occurs, tx_ready SHALL become 1 on the next cycle.
- REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit used to distinguish full from empty.
- REQ-021 tx_data SHALL be captured only at acceptance; a later change to tx_data SHALL NOT corrupt a queued or in-flight byte.

Reset
- REQ-022 While rst is high, the block SHALL set: FSM = IDLE, ser_out = 1, busy = 0, fifo_count = 0, tx_ready = 0, all pointers and counters = 0.
- REQ-023 A reset asserted mid-frame SHALL abort the frame and drop FIFO contents; ser_out SHALL be 1 from the edge after rst is sampled high, and tx_ready SHALL be 1 on the first cycle after rst falls.

Configuration
- REQ-024 With macro DKONG_UART_PARITY_EN defined, the block SHALL insert the PARITY state, which drives the even parity of the 8 data bits for one bit period.
- REQ-025 Without DKONG_UART_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP; the frame is 10 bit periods long.

Structure
- REQ-026 The shared package dkong_uart_pkg SHALL hold the FSM state encoding, START_BIT=0, STOP_BIT=1 and DATA_BITS=8, for reuse by the matching receiver.
- REQ-027 The FIFO SHALL be a sub-module named dkong_uart_fifo, parameterised by width and depth, with push, pop, full, empty and count.

Verification
- REQ-028 Basic frame: CLKS_PER_BIT=4, no parity, push 0xA5 -> ser_out carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, with the start bit beginning 2 cycles after acceptance.
- REQ-029 Back-to-back: push 0x00 then 0xFF on consecutive cycles -> 20 contiguous bit periods with no idle cycles; busy drops 1 cycle after the second stop bit ends.
- REQ-030 FIFO full: FIFO_DEPTH=4 with tx_valid held high -> 5 bytes accepted (1 in the shifter and 4 queued), then tx_ready=0; bytes emerge in order and none are lost or duplicated.
- REQ-031 Parity: DKONG_UART_PARITY_EN defined, push 0x07 -> parity bit 1; push 0x03 -> parity bit 0; each frame is 11 bit periods.
- REQ-032 Mid-frame reset: assert rst during data bit 3 -> ser_out=1 on the next cycle and fifo_count=0; after release, push 0x3C -> a clean frame is transmitted.
- REQ-033 CLKS_PER_BIT=1: push 0x81 -> each bit lasts exactly 1 cycle, and the frame is 10 cycles long.
